aes_dec_seq: RTL and testbench

AES_DEC_SEQ -- requirements
Module: aes_dec_seq

---
 rtl/aes_pkg.sv | 71 +++++++
 rtl/inv_round_comb.sv | 44 ++++
 rtl/aes_dec_seq.sv | 112 +++++++++++
 tb/tb_aes_dec_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: FSM states, round constants, GF(2^8) helpers
// and the forward key-expansion step.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {StIdle, StKexp, StRound, StDone} fsm_e;

  // Byte 0 of the FIPS-197 byte order sits in element [15].
  typedef logic [15:0][7:0] blk_t;

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Packed position of state byte (column c, row r).
  function automatic logic [3:0] bidx(input int c, input int r);
    return 4'(15 - 4 * c - r);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic blk_t key_step(input blk_t rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[15:12];
    w1 = rk[11:8];
    w2 = rk[7:4];
    w3 = rk[3:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One combinational inverse round: AddRoundKey, optional InvMixColumns, InvShiftRows and
// InvSubBytes.
module inv_round_comb
  import aes_pkg::*;
(
  input  blk_t data,
  input  blk_t rk,
  input  logic first,
  output blk_t result
);

  blk_t       x;
  blk_t       m;
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    x      = data ^ rk;
    m      = x;
    a0     = 8'h00;
    a1     = 8'h00;
    a2     = 8'h00;
    a3     = 8'h00;
    result = '0;
    if (!first) begin
      for (int c = 0; c < 4; c++) begin
        a0 = x[bidx(c, 0)];
        a1 = x[bidx(c, 1)];
        a2 = x[bidx(c, 2)];
        a3 = x[bidx(c, 3)];
        m[bidx(c, 0)] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        m[bidx(c, 1)] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        m[bidx(c, 2)] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        m[bidx(c, 3)] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
    end
    // Row r rotates right by r: output column c takes input column (c - r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        result[bidx(c, r)] = inv_sbox(m[bidx((c - r + 4) % 4, r)]);
      end
    end
  end

endmodule

// File: rtl/aes_dec_seq.sv
// Iterative AES-128 decryptor: on-the-fly forward key expansion then ten inverse rounds.
// Optional macro AES_DEC_KEY_CACHE_EN skips expansion when the key repeats.
module aes_dec_seq
  import aes_pkg::*;
#(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0][7:0] state,
  input  logic [15:0][7:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] out,
  output logic             busy
);

  fsm_e       fsm_q;
  logic [3:0] cnt_q;
  blk_t       data_q;
  blk_t       rk_q [0:10];
  blk_t       kexp_out;
  blk_t       rnd_out;
  logic       key_hit;

`ifdef AES_DEC_KEY_CACHE_EN
  logic cache_valid_q;
  // rk_q[0] holds the key whose expansion is cached once the flag is set.
  assign key_hit = cache_valid_q && (key == rk_q[0]);
`else
  assign key_hit = 1'b0;
`endif

  assign kexp_out = key_step(rk_q[cnt_q - 4'd1], RCON[cnt_q]);

  inv_round_comb u_inv_round (
    .data  (data_q),
    .rk    (rk_q[cnt_q]),
    .first (cnt_q == 4'(NR)),
    .result(rnd_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= StIdle;
      cnt_q     <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_valid_q <= 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            data_q   <= state;
            rk_q[0]  <= key;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (key_hit) begin
              fsm_q <= StRound;
              cnt_q <= 4'(NR);
            end else begin
              fsm_q <= StKexp;
              cnt_q <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
              cache_valid_q <= 1'b0;
`endif
            end
          end
        end
        StKexp: begin
          rk_q[cnt_q] <= kexp_out;
          if (cnt_q == 4'(NR)) begin
            // Counter stays at NR: the first inverse round consumes rk[NR].
            fsm_q <= StRound;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_valid_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StRound: begin
          data_q <= rnd_out;
          if (cnt_q == 4'd1) begin
            out       <= rnd_out ^ rk_q[0];
            out_valid <= 1'b1;
            fsm_q     <= StDone;
            cnt_q     <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm_q     <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_seq.sv
// Bench for aes_dec_seq: FIPS-197 vectors plus random blocks encrypted by a reference
// AES-128 encryptor whose S-box is built by a generator walk.
module tb_aes_dec_seq;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [15:0][7:0] state;
  logic [15:0][7:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [15:0][7:0] out;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox [256];
  logic         cache_ok;
  logic [127:0] cache_key;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;

  aes_dec_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .state    (state),
    .key      (key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ w[i / 4][31 - 8 * (i % 4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4 * c + r] = s[4 * ((c + r) % 4) + r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
          t[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4 * rnd + i / 4][31 - 8 * (i % 4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
    return (cache_ok && k == cache_key) ? 11 : 21;
`else
    return 21;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one pair for a single edge, then scrambles the inputs the DUT must ignore.
  task automatic start(input logic [127:0] k, input logic [127:0] ct);
    key      = k;
    state    = ct;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    key      = rnd128();
    state    = rnd128();
  endtask

  // Called in cycle T+1; n tracks the cycle offset from the accept cycle T.
  task automatic wait_result(input string tag, input logic [127:0] pt, input int lat);
    int n;
    n = 1;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " out"}, out, pt);
  endtask

  task automatic finish_hs(input string tag);
    step();
    check({tag, " in_ready after handshake"}, in_ready, 1'b1);
    check({tag, " out_valid after handshake"}, out_valid, 1'b0);
  endtask

  task automatic run(input string tag, input logic [127:0] k, input logic [127:0] ct,
                     input logic [127:0] pt);
    int lat;
    lat = exp_lat(k);
    start(k, ct);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " in_ready low"}, in_ready, 1'b0);
    wait_result(tag, pt, lat);
    cache_ok  = 1'b1;
    cache_key = k;
    finish_hs(tag);
  endtask

  initial begin
    logic [7:0]   p, q, x;
    logic [127:0] held, k, pt;
    int           lat;
    int           seen;

    // S-box by walking generator 3 and its inverse in lockstep.
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;

    cache_ok  = 1'b0;
    cache_key = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    state     = '0;
    key       = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset out", out, '0);

    run("fips c1", C1_KEY, C1_CT, C1_PT);
    run("b2b second", C1_KEY, C1_CT, C1_PT);

    // Backpressure: result held, new pairs refused while DONE waits.
    out_ready = 1'b0;
    lat = exp_lat(B_KEY);
    start(B_KEY, B_CT);
    wait_result("bp", B_PT, lat);
    cache_ok  = 1'b1;
    cache_key = B_KEY;
    held = out;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      key      = rnd128();
      state    = rnd128();
      step();
      check("bp out stable", out, held);
      check("bp out_valid held", out_valid, 1'b1);
      check("bp in_ready low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    key       = C1_KEY;
    state     = C1_CT;
    step();
    check("bp release in_ready", in_ready, 1'b1);
    check("bp release out_valid", out_valid, 1'b0);
    check("bp out kept after handshake", out, held);
    lat = exp_lat(C1_KEY);
    step();
    in_valid = 1'b0;
    check("bp single accept busy", busy, 1'b1);
    wait_result("bp next", C1_PT, lat);
    cache_ok  = 1'b1;
    cache_key = C1_KEY;
    finish_hs("bp next");
    step();
    check("bp no second accept", busy, 1'b0);

    // Reset sampled at the end of cycle T+15.
    start(C1_KEY, C1_CT);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    cache_ok = 1'b0;
    step();
    check("rst in_ready at T+17", in_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst out cleared", out, '0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("rst no output", seen, 0);
    run("post reset c1", C1_KEY, C1_CT, C1_PT);

    run("fips b key change", B_KEY, B_CT, B_PT);

    k = rnd128();
    for (int i = 0; i < 8; i++) begin
      if (i % 3 != 2) k = rnd128();
      pt = rnd128();
      run("random", k, aes_enc(pt, k), pt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
